// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the decode-stage handshake, the instruction fields and the
// registered results of alu_op_sequencer.
//   master : issue side (ID stage / hazard unit); drives in_valid, ALUOp,
//            Funct7, Funct3, hold, flush and observes every result.
//   slave  : the sequencer; drives in_ready, Operation, op_valid, illegal,
//            m_start, m_busy, m_done.
interface alu_op_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic       hold;
  logic       flush;
  logic [4:0] Operation;
  logic       op_valid;
  logic       illegal;
  logic       m_start;
  logic       m_busy;
  logic       m_done;

  modport master (
    output in_valid, ALUOp, Funct7, Funct3, hold, flush,
    input  in_ready, Operation, op_valid, illegal, m_start, m_busy, m_done
  );

  modport slave (
    input  in_valid, ALUOp, Funct7, Funct3, hold, flush,
    output in_ready, Operation, op_valid, illegal, m_start, m_busy, m_done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Registered ALU operation decoder for the ID/EX boundary. Decodes
// ALUOp/Funct7/Funct3 into a 5-bit operation and, for RV32M ops, runs an
// IDLE/BUSY sequence that stalls the stage for MUL_LAT or DIV_LAT cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_op_sequencer_if.slave (handshake, fields, hold/flush,
//           Operation/op_valid/illegal, m_start/m_busy/m_done)
module alu_op_sequencer #(
  parameter bit EN_M    = 1'b1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic               clk,
  input  logic               reset,
  alu_op_sequencer_if.slave  bus
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01001;
  localparam logic [4:0] OP_SLTU = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  // The counter is loaded with LAT-1 so that the final busy cycle sees cnt==0.
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  logic [4:0] op_reg, op_next;
  logic       illegal_reg, illegal_next;
  logic       op_valid_reg, op_valid_next;
  logic       m_start_reg, m_start_next;

  logic [4:0] dec_op;
  logic       dec_illegal;
  logic       dec_is_m;
  logic       in_ready;
  logic       accept;

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    dec_is_m    = 1'b0;
    unique case (bus.ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        unique case (bus.Funct3)
          3'b000, 3'b001: dec_op = OP_SUB;
          3'b100, 3'b101: dec_op = OP_SLT;
          3'b110, 3'b111: dec_op = OP_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (bus.Funct7 == F7_BASE) begin
          unique case (bus.Funct3)
            3'b000: dec_op = OP_ADD;
            3'b001: dec_op = OP_SLL;
            3'b010: dec_op = OP_SLT;
            3'b011: dec_op = OP_SLTU;
            3'b100: dec_op = OP_XOR;
            3'b101: dec_op = OP_SRL;
            3'b110: dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (bus.Funct7 == F7_ALT && bus.Funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (bus.Funct7 == F7_ALT && bus.Funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else if (EN_M && bus.Funct7 == F7_M) begin
          dec_op   = {2'b11, bus.Funct3};
          dec_is_m = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: begin
        // I-type: Funct7 only qualifies the shift encodings.
        unique case (bus.Funct3)
          3'b000: dec_op = OP_ADD;
          3'b001: begin
            if (bus.Funct7 == F7_BASE) dec_op = OP_SLL;
            else                       dec_illegal = 1'b1;
          end
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b101: begin
            if (bus.Funct7 == F7_BASE)     dec_op = OP_SRL;
            else if (bus.Funct7 == F7_ALT) dec_op = OP_SRA;
            else                           dec_illegal = 1'b1;
          end
          3'b110: dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
    endcase
  end

  // ------------------------------------------------------------ handshake
  // The last busy cycle (cnt==0) may accept the next op back-to-back.
  assign in_ready = ~bus.hold & ~bus.flush &
                    ((state_reg == IDLE) | ((state_reg == BUSY) & (cnt_reg == 6'd0)));
  assign accept   = bus.in_valid & in_ready;

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_next       = op_reg;
    illegal_next  = illegal_reg;
    op_valid_next = op_valid_reg & bus.hold;  // a pending op is held, not lost
    m_start_next  = 1'b0;

    // The counter runs regardless of hold; cnt==0 is the final busy cycle.
    if (state_reg == BUSY) begin
      if (cnt_reg == 6'd0) state_next = IDLE;
      else                 cnt_next   = cnt_reg - 6'd1;
    end

    if (accept) begin
      op_next       = dec_op;
      illegal_next  = dec_illegal;
      op_valid_next = 1'b1;
      if (dec_is_m) begin
        m_start_next = 1'b1;
        state_next   = BUSY;
        cnt_next     = bus.Funct3[2] ? DIV_CNT : MUL_CNT;
      end
    end

    // Flush wins over everything; it also suppresses any later m_done.
    if (bus.flush) begin
      state_next    = IDLE;
      cnt_next      = 6'd0;
      op_valid_next = 1'b0;
      m_start_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 6'd0;
      op_reg       <= OP_AND;
      illegal_reg  <= 1'b0;
      op_valid_reg <= 1'b0;
      m_start_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_reg       <= op_next;
      illegal_reg  <= illegal_next;
      op_valid_reg <= op_valid_next;
      m_start_reg  <= m_start_next;
    end
  end

  // --------------------------------------------------------------- outputs
  assign bus.in_ready  = in_ready;
  assign bus.Operation = op_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.op_valid  = op_valid_reg;
  assign bus.m_start   = m_start_reg;
  assign bus.m_busy    = (state_reg == BUSY);
  assign bus.m_done    = (state_reg == BUSY) & (cnt_reg == 6'd0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer. A default build (EN_M=1, MUL_LAT=3,
// DIV_LAT=33) and an EN_M=0 build see identical stimulus; expected values
// are hand-computed constants.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  alu_op_sequencer_if bus ();
  alu_op_sequencer_if bus_nom ();

  alu_op_sequencer #(.EN_M(1'b1), .MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  alu_op_sequencer #(.EN_M(1'b0), .MUL_LAT(3), .DIV_LAT(33)) dut_nom (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nom.slave)
  );

  assign bus_nom.in_valid = bus.in_valid;
  assign bus_nom.ALUOp    = bus.ALUOp;
  assign bus_nom.Funct7   = bus.Funct7;
  assign bus_nom.Funct3   = bus.Funct3;
  assign bus_nom.hold     = bus.hold;
  assign bus_nom.flush    = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] br_exp [8] = '{5'b00110, 5'b00110, 5'b00010, 5'b00010,
                             5'b01001, 5'b01001, 5'b01010, 5'b01010};
  logic       br_ill [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one op for one cycle; returns in the cycle after the edge.
  task automatic issue(input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3);
    bus.ALUOp    = a;
    bus.Funct7   = f7;
    bus.Funct3   = f3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.Funct7   = 7'd0;
    bus.Funct3   = 3'd0;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;
    tick();
    tick();
    #1;
    check("rst_operation", bus.Operation, 5'b00000);
    check("rst_op_valid",  bus.op_valid,  1'b0);
    check("rst_illegal",   bus.illegal,   1'b0);
    check("rst_m_start",   bus.m_start,   1'b0);
    check("rst_m_busy",    bus.m_busy,    1'b0);
    check("rst_m_done",    bus.m_done,    1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    reset = 1'b0;
    tick();
    $display("reset checks done");

    // R-type SUB.
    issue(2'b10, 7'b0100000, 3'b000);
    check("sub_operation", bus.Operation, 5'b00110);
    check("sub_op_valid",  bus.op_valid,  1'b1);
    check("sub_in_ready",  bus.in_ready,  1'b1);
    tick();
    #1;
    check("sub_op_valid_drop", bus.op_valid, 1'b0);
    $display("txn SUB: Operation=%b", bus.Operation);

    // Branch Funct3 sweep.
    for (int i = 0; i < 8; i++) begin
      issue(2'b01, 7'b1111111, 3'(i));
      check("br_operation", bus.Operation, br_exp[i]);
      check("br_illegal",   bus.illegal,   br_ill[i]);
      check("br_op_valid",  bus.op_valid,  1'b1);
      $display("txn BR f3=%0d: Operation=%b illegal=%b", i, bus.Operation, bus.illegal);
    end
    tick();

    // I-type SLLI with a bad Funct7, and with a good one.
    issue(2'b11, 7'b0000001, 3'b001);
    check("islli_bad_illegal", bus.illegal,   1'b1);
    check("islli_bad_op",      bus.Operation, 5'b00010);
    check("islli_bad_m_start", bus.m_start,   1'b0);
    check("islli_bad_m_busy",  bus.m_busy,    1'b0);
    issue(2'b11, 7'b0000000, 3'b001);
    check("islli_op",      bus.Operation, 5'b00111);
    check("islli_illegal", bus.illegal,   1'b0);
    $display("txn SLLI: Operation=%b", bus.Operation);
    tick();

    // DIV, latency 33; the EN_M=0 build must flag it illegal.
    issue(2'b10, 7'b0000001, 3'b100);
    check("div_m_start",   bus.m_start,   1'b1);
    check("div_op_valid",  bus.op_valid,  1'b1);
    check("div_operation", bus.Operation, 5'b11100);
    check("div_m_busy",    bus.m_busy,    1'b1);
    check("div_m_done",    bus.m_done,    1'b0);
    check("div_in_ready",  bus.in_ready,  1'b0);
    check("nom_illegal",   bus_nom.illegal,   1'b1);
    check("nom_operation", bus_nom.Operation, 5'b00010);
    check("nom_m_start",   bus_nom.m_start,   1'b0);
    check("nom_m_busy",    bus_nom.m_busy,    1'b0);
    for (int k = 2; k <= 32; k++) begin
      tick();
      #1;
      check("div_busy_mid",    bus.m_busy,   1'b1);
      check("div_done_mid",    bus.m_done,   1'b0);
      check("div_ready_mid",   bus.in_ready, 1'b0);
      check("div_start_mid",   bus.m_start,  1'b0);
    end
    tick();
    #1;
    check("div_done_last",  bus.m_done,   1'b1);
    check("div_busy_last",  bus.m_busy,   1'b1);
    check("div_ready_last", bus.in_ready, 1'b1);
    issue(2'b10, 7'b0000000, 3'b110);
    check("b2b_op_valid",  bus.op_valid,  1'b1);
    check("b2b_operation", bus.Operation, 5'b00001);
    check("b2b_m_busy",    bus.m_busy,    1'b0);
    check("b2b_m_done",    bus.m_done,    1'b0);
    $display("txn DIV then OR: Operation=%b", bus.Operation);
    tick();

    // MUL, latency 3, flushed at t+2 with a competing op offered.
    issue(2'b10, 7'b0000001, 3'b000);
    check("mul_m_start",   bus.m_start,   1'b1);
    check("mul_operation", bus.Operation, 5'b11000);
    tick();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.ALUOp    = 2'b10;
    bus.Funct7   = 7'b0000000;
    bus.Funct3   = 3'b001;
    #1;
    check("mulf_in_ready", bus.in_ready, 1'b0);
    check("mulf_m_done",   bus.m_done,   1'b0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mulf_m_busy",   bus.m_busy,   1'b0);
    check("mulf_m_done2",  bus.m_done,   1'b0);
    check("mulf_op_valid", bus.op_valid, 1'b0);
    check("mulf_in_ready2", bus.in_ready, 1'b1);
    issue(2'b10, 7'b0000000, 3'b100);
    check("postf_op_valid",  bus.op_valid,  1'b1);
    check("postf_operation", bus.Operation, 5'b00011);
    check("postf_m_done",    bus.m_done,    1'b0);
    $display("txn MUL flushed, XOR: Operation=%b", bus.Operation);
    tick();

    // hold blocks acceptance for 4 cycles.
    bus.hold     = 1'b1;
    bus.in_valid = 1'b1;
    bus.ALUOp    = 2'b11;
    bus.Funct7   = 7'b0100000;
    bus.Funct3   = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("hold_in_ready", bus.in_ready, 1'b0);
      tick();
      #1;
      check("hold_op_valid", bus.op_valid,  1'b0);
      check("hold_operation", bus.Operation, 5'b00011);
    end
    bus.hold = 1'b0;
    #1;
    check("rel_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    // Hold again straight away: op_valid must persist.
    bus.hold = 1'b1;
    #1;
    check("rel_operation", bus.Operation, 5'b01011);
    check("rel_op_valid",  bus.op_valid,  1'b1);
    tick();
    #1;
    check("held_op_valid", bus.op_valid, 1'b1);
    bus.hold = 1'b0;
    tick();
    #1;
    check("unheld_op_valid", bus.op_valid, 1'b0);
    $display("txn SRAI under hold: Operation=%b", bus.Operation);

    // Reset in the middle of a DIV.
    issue(2'b10, 7'b0000001, 3'b111);
    check("remu_operation", bus.Operation, 5'b11111);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mrst_m_busy",    bus.m_busy,    1'b0);
    check("mrst_m_done",    bus.m_done,    1'b0);
    check("mrst_op_valid",  bus.op_valid,  1'b0);
    check("mrst_operation", bus.Operation, 5'b00000);
    check("mrst_in_ready",  bus.in_ready,  1'b1);
    $display("txn REMU reset mid-sequence: m_busy=%b", bus.m_busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered, parametrised ALU operation decoder for the ID/EX boundary of the pipelined RV32 core. Decodes ALUOp/Funct7/Funct3 into a 5-bit ALU operation for R-type, I-type, branch and load/store instructions. It also adds RV32M decode with multi-cycle sequencing: a busy counter, stall request and done pulse toward the multiply/divide unit. It replaces the purely combinational operation select with a valid/ready-handshaked, flushable stage.

## Interface
- EN_M, 1: 1 enables RV32M decode and sequencing; 0 flags Funct7=0000001 as illegal.
- MUL_LAT, 3: cycles a MUL/MULH/MULHSU/MULHU occupies the stage (1..15).
- DIV_LAT, 33: cycles a DIV/DIVU/REM/REMU occupies the stage (1..63).
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode fields valid this cycle.
- in_ready  out  1  stage accepts this cycle.
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- Funct7  in  7  instruction bits 31:25.
- Funct3  in  3  instruction bits 14:12.
- hold  in  1  downstream stall from the hazard unit.
- flush  in  1  kill the registered op and any M sequence.
- Operation  out  5  registered ALU operation.
- op_valid  out  1  Operation is new this cycle.
- illegal  out  1  registered; the accepted combination is unsupported.
- m_start  out  1  one-cycle pulse launching the M unit.
- m_busy  out  1  M sequence in progress; doubles as the stall request.
- m_done  out  1  one-cycle pulse in the last busy cycle.

## Operation
- Encodings:
  - AND 00000, OR 00001, ADD 00010, XOR 00011, SUB 00110, SLL 00111.
  - SRL 01000, SLT 01001, SLTU 01010, SRA 01011.
  - M ops are {2'b11, Funct3}: MUL 11000 through REMU 11111.
- ALUOp 00: ADD, with Funct7 and Funct3 ignored.
- ALUOp 01, branch compare:
  - Funct3 000/001 → SUB.
  - Funct3 100/101 → SLT.
  - Funct3 110/111 → SLTU.
  - Funct3 010/011 is illegal.
- ALUOp 10, R-type:
  - Funct7=0000000 decodes all eight Funct3 values: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - Funct7=0100000 is legal only with Funct3 000 (SUB) and 101 (SRA).
  - Funct7=0000001 is an M op when EN_M=1.
  - Anything else is illegal.
- ALUOp 11, I-type:
  - Funct7 is ignored except for shifts.
  - Funct3 001 needs Funct7=0000000.
  - Funct3 101 takes 0000000 for SRL and 0100000 for SRA.
  - No SUB and no M ops.
- Illegal combination: Operation=ADD, illegal=1, no M sequence.
- FSM states: IDLE and BUSY. A 6-bit counter cnt covers DIV_LAT up to 63.
- IDLE:
  - Accept when in_valid & in_ready.
  - An accepted M op loads cnt = LAT-1 and enters BUSY; LAT is MUL_LAT for Funct3[2]=0, DIV_LAT otherwise.
- BUSY:
  - cnt decrements each cycle.
  - m_done = (cnt==0); the FSM returns to IDLE after that cycle.
  - hold does not pause cnt.
- in_ready = ~hold & ~flush & (IDLE | (BUSY & cnt==0)).
  - Back-to-back accept in the m_done cycle is legal.
- Outputs on acceptance:
  - op_valid is set the cycle after acceptance, for one cycle only.
  - Operation and illegal stay stable until the next acceptance.
  - m_start is asserted with op_valid for M ops only.
- hold:
  - Blocks acceptance.
  - Does not clear an op_valid already asserted; op_valid stays high while hold=1.
- flush:
  - Highest priority.
  - Next cycle: op_valid=0, m_busy=0, FSM in IDLE, cnt=0.
  - No m_done is generated.
  - A same-cycle in_valid is dropped.

## Timing
- Reset values:
  - Outputs: Operation=00000, op_valid=0, illegal=0, m_start=0, m_busy=0, m_done=0.
  - Internal: FSM in IDLE, cnt=0.
  - in_ready=1 after reset if hold=0.
- Latency: accept at cycle t → Operation and op_valid at t+1.
- M op with latency L, accepted at t:
  - m_start and op_valid at t+1.
  - m_busy=1 over t+1..t+L.
  - m_done at t+L.
  - L=1: m_start and m_done in the same cycle.
- Reset mid-sequence: next cycle all outputs at reset values, with no m_done.
- Flush during the m_done cycle:
  - m_done is still asserted in that cycle.
  - The input offered in that cycle is not accepted.

## Test plan
- Reset, then ALUOp=10, F7=0100000, F3=000, in_valid for one cycle → Operation=00110, op_valid=1 for exactly one cycle, in_ready stays 1.
- Sweep every branch Funct3 with ALUOp=01:
  - 000/001 → 00110.
  - 100/101 → 01001.
  - 110/111 → 01010.
  - 010 → illegal=1 with Operation=00010.
- DIV (F7=0000001, F3=100) with DIV_LAT=33, accepted at t:
  - m_start at t+1, m_busy high for 33 cycles, m_done at t+33, in_ready=0 over t+1..t+32.
  - A second op offered at t+33 shows op_valid at t+34.
- MUL with MUL_LAT=3, flush at t+2 → m_busy=0 at t+3, m_done never pulses, next op accepted at t+3.
- hold=1 with in_valid=1 for 4 cycles → in_ready=0 and no new op_valid; on hold release the op is accepted and Operation updates one cycle later.
- EN_M=0 build, R-type F7=0000001 → illegal=1, m_start=0, m_busy=0.
